// File: rtl/boot_sequencer_if.sv
// Signal bundle between boot_sequencer and the MIPS datapath / program source.
// master = sequencer side, slave = datapath and program-source side.
interface boot_sequencer_if;
    logic        start;
    logic [15:0] progLen;
    logic        loadValid;
    logic [31:0] loadData;
    logic        loadReady;
    logic [31:0] instrAddrOut;
    logic [31:0] instrDataOut;
    logic        instrWrite;
    logic        instrRead;
    logic        initializing;
    logic        pcReset;
    logic        pcWrite;
    logic [31:0] pcValue;
    logic        dumpRegEn;
    logic [4:0]  dumpRegAddr;
    logic [31:0] regDataIn;
    logic        dumpValid;
    logic [4:0]  dumpIdx;
    logic [31:0] dumpData;
    logic [15:0] cycleNo;
    logic        done;
    logic        timeout;
    logic        progErr;

    modport master (
        input  start, progLen, loadValid, loadData, pcValue, regDataIn,
        output loadReady, instrAddrOut, instrDataOut, instrWrite, instrRead,
               initializing, pcReset, pcWrite, dumpRegEn, dumpRegAddr,
               dumpValid, dumpIdx, dumpData, cycleNo, done, timeout, progErr
    );

    modport slave (
        output start, progLen, loadValid, loadData, pcValue, regDataIn,
        input  loadReady, instrAddrOut, instrDataOut, instrWrite, instrRead,
               initializing, pcReset, pcWrite, dumpRegEn, dumpRegAddr,
               dumpValid, dumpIdx, dumpData, cycleNo, done, timeout, progErr
    );
endinterface

// File: rtl/boot_sequencer.sv
// Run controller for the single-cycle MIPS datapath: load program, run with watchdog, optional dump.
// Define BOOT_REGDUMP_EN to include the register-dump phase; otherwise RUN ends directly in DONE.
module boot_sequencer #(
    parameter int unsigned PROG_WORDS_MAX = 256,
    parameter int unsigned MAX_CYCLES     = 1024,
    parameter int unsigned NUM_REGS       = 32
) (
    input  logic             clk,
    input  logic             resetN,
    boot_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_e;

    localparam logic [15:0] WD_LAST   = 16'(MAX_CYCLES - 1);
    localparam logic [5:0]  DUMP_LAST = 6'(NUM_REGS);
    localparam logic [4:0]  ADDR_LAST = 5'(NUM_REGS - 1);

`ifdef BOOT_REGDUMP_EN
    localparam state_e RUN_EXIT = S_DUMP;
`else
    localparam state_e RUN_EXIT = S_DONE;
`endif

    state_e      state_q, state_d;
    logic [15:0] progLen_q, progLen_d;
    logic [15:0] wordIdx_q, wordIdx_d;
    logic [15:0] cycleNo_q, cycleNo_d;
    logic        timeout_q, timeout_d;
    logic        progErr_q, progErr_d;
    logic [5:0]  dumpCnt_q, dumpCnt_d;

    logic        loadReady_c;
    logic        instrWrite_c;
    logic        instrRead_c;
    logic        initializing_c;
    logic        pcReset_c;
    logic        pcWrite_c;
    logic        dumpRegEn_c;
    logic        done_c;

    logic        pcEnd;
    logic        wdEnd;
    logic        badLen;
    logic [4:0]  dumpAddr;

    assign pcEnd    = bus.pcValue >= {14'd0, progLen_q, 2'b00};
    assign wdEnd    = cycleNo_q == WD_LAST;
    assign badLen   = (bus.progLen == '0) || (32'(bus.progLen) > PROG_WORDS_MAX);
    // Address holds at the last register during the final cycle that only emits it.
    assign dumpAddr = (dumpCnt_q < DUMP_LAST) ? dumpCnt_q[4:0] : ADDR_LAST;
    assign dumpCnt_d = dumpRegEn_c ? dumpCnt_q + 6'd1 : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            progLen_q <= '0;
            wordIdx_q <= '0;
            cycleNo_q <= '0;
            timeout_q <= 1'b0;
            progErr_q <= 1'b0;
            dumpCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            progLen_q <= progLen_d;
            wordIdx_q <= wordIdx_d;
            cycleNo_q <= cycleNo_d;
            timeout_q <= timeout_d;
            progErr_q <= progErr_d;
            dumpCnt_q <= dumpCnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        progLen_d      = progLen_q;
        wordIdx_d      = wordIdx_q;
        cycleNo_d      = cycleNo_q;
        timeout_d      = timeout_q;
        progErr_d      = progErr_q;
        loadReady_c    = 1'b0;
        instrWrite_c   = 1'b0;
        instrRead_c    = 1'b0;
        initializing_c = 1'b1;
        pcReset_c      = 1'b1;
        pcWrite_c      = 1'b0;
        dumpRegEn_c    = 1'b0;
        done_c         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done_c = (state_q == S_DONE);
                if (bus.start) begin
                    progLen_d = bus.progLen;
                    wordIdx_d = '0;
                    cycleNo_d = '0;
                    timeout_d = 1'b0;
                    progErr_d = badLen;
                    state_d   = badLen ? S_DONE : S_LOAD;
                end
            end

            S_LOAD: begin
                loadReady_c  = 1'b1;
                instrWrite_c = bus.loadValid;
                if (bus.loadValid) begin
                    wordIdx_d = wordIdx_q + 16'd1;
                    if (wordIdx_q == progLen_q - 16'd1) begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                pcReset_c      = 1'b0;
                pcWrite_c      = 1'b1;
                instrRead_c    = 1'b1;
                initializing_c = 1'b0;
                // PC reaching the end takes priority over the watchdog in the same cycle.
                if (pcEnd) begin
                    state_d = RUN_EXIT;
                end else if (wdEnd) begin
                    timeout_d = 1'b1;
                    state_d   = RUN_EXIT;
                end else if (cycleNo_q != 16'hFFFF) begin
                    cycleNo_d = cycleNo_q + 16'd1;
                end
            end

            S_DUMP: begin
                pcReset_c      = 1'b0;
                initializing_c = 1'b0;
                dumpRegEn_c    = 1'b1;
                if (dumpCnt_q == DUMP_LAST) begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.loadReady    = loadReady_c;
    assign bus.instrAddrOut = {14'd0, wordIdx_q, 2'b00};
    assign bus.instrDataOut = bus.loadData;
    assign bus.instrWrite   = instrWrite_c;
    assign bus.instrRead    = instrRead_c;
    assign bus.initializing = initializing_c;
    assign bus.pcReset      = pcReset_c;
    assign bus.pcWrite      = pcWrite_c;
    assign bus.dumpRegAddr  = dumpAddr;
    assign bus.cycleNo      = cycleNo_q;
    assign bus.done         = done_c;
    assign bus.timeout      = timeout_q;
    assign bus.progErr      = progErr_q;

`ifdef BOOT_REGDUMP_EN
    logic        dumpValid_q;
    logic [4:0]  dumpIdx_q;
    logic [31:0] dumpData_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dumpValid_q <= 1'b0;
            dumpIdx_q   <= '0;
            dumpData_q  <= '0;
        end else if (dumpRegEn_c && (dumpCnt_q < DUMP_LAST)) begin
            dumpValid_q <= 1'b1;
            dumpIdx_q   <= dumpAddr;
            dumpData_q  <= bus.regDataIn;
        end else begin
            dumpValid_q <= 1'b0;
        end
    end

    assign bus.dumpRegEn = dumpRegEn_c;
    assign bus.dumpValid = dumpValid_q;
    assign bus.dumpIdx   = dumpIdx_q;
    assign bus.dumpData  = dumpData_q;
`else
    assign bus.dumpRegEn = 1'b0;
    assign bus.dumpValid = 1'b0;
    assign bus.dumpIdx   = '0;
    assign bus.dumpData  = '0;
`endif
endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: directed and randomized load/run/dump sequences.
// Expected run length and watchdog outcome are derived arithmetically from program length and PC step.
module tb_boot_sequencer;
    localparam int unsigned PW = 256;
    localparam int unsigned MC = 16;
    localparam int unsigned NR = 32;
    localparam logic [10:0] RESET_VEC = 11'b110_0000_0000;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    boot_sequencer_if bus ();

    boot_sequencer #(
        .PROG_WORDS_MAX(PW),
        .MAX_CYCLES    (MC),
        .NUM_REGS      (NR)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] pc;
    logic [31:0] pcStep = 32'd4;
    logic [31:0] regs [NR];
    logic [31:0] prog [64];
    int          stall [64];

    // Environment: PC register and register-file read port.
    always @(posedge clk or negedge resetN) begin
        if (!resetN)          pc <= '0;
        else if (bus.pcReset) pc <= '0;
        else if (bus.pcWrite) pc <= pc + pcStep;
    end
    assign bus.pcValue   = pc;
    assign bus.regDataIn = bus.dumpRegEn ? regs[bus.dumpRegAddr] : 32'hDEAD_BEEF;

    // Passive recorder sampled on the falling edge.
    int          cyc = 0;
    int          wrCyc [$];
    logic [31:0] wrAddr [$];
    logic [31:0] wrData [$];
    logic [4:0]  dIdx [$];
    logic [31:0] dData [$];
    int          badWr = 0, runCnt = 0, firstRun = 0, lastRun = 0, doneCyc = -1, dumpEnCnt = 0;
    logic        prevDone = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.instrWrite) begin
            wrCyc.push_back(cyc);
            wrAddr.push_back(bus.instrAddrOut);
            wrData.push_back(bus.instrDataOut);
            if (!bus.loadValid) badWr = badWr + 1;
        end
        if (bus.pcWrite) begin
            if (runCnt == 0) firstRun = cyc;
            lastRun = cyc;
            runCnt  = runCnt + 1;
        end
        if (bus.dumpValid) begin
            dIdx.push_back(bus.dumpIdx);
            dData.push_back(bus.dumpData);
        end
        if (bus.dumpRegEn) dumpEnCnt = dumpEnCnt + 1;
        if (bus.done && !prevDone && doneCyc < 0) doneCyc = cyc;
        prevDone = bus.done;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic clear_mon();
        wrCyc.delete(); wrAddr.delete(); wrData.delete();
        dIdx.delete(); dData.delete();
        badWr = 0; runCnt = 0; firstRun = 0; lastRun = 0; doneCyc = -1; dumpEnCnt = 0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < 64; i++) begin
            prog[i]  = (i < n) ? $urandom() : 32'h0;
            stall[i] = 0;
        end
        for (int r = 0; r < int'(NR); r++) regs[r] = $urandom();
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.progLen = '0; bus.loadValid = 1'b0; bus.loadData = '0;
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    // Callers sit at posedge+1; start is held across exactly one rising edge.
    task automatic start_prog(input int len);
        bus.progLen = 16'(len);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic load_words(input int n);
        int b;
        for (int i = 0; i < n; i++) begin
            bus.loadValid = 1'b0;
            repeat (stall[i]) begin @(posedge clk); #1; end
            b = 0;
            while (!bus.loadReady && b < 20) begin @(posedge clk); #1; b++; end
            if (!bus.loadReady) begin
                checks++; errors++;
                $display("FAIL load_ready: word %0d loadReady=%b, required 1", i, bus.loadReady);
                bus.loadValid = 1'b0;
                return;
            end
            bus.loadValid = 1'b1;
            bus.loadData  = prog[i];
            @(posedge clk); #1;
        end
        bus.loadValid = 1'b0;
        bus.loadData  = $urandom();
    endtask

    task automatic wait_done(input int budget, input string name);
        int b = 0;
        while (!bus.done && b < budget) begin @(posedge clk); #1; b++; end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_wait: done=%b after %0d cycles, required 1", name, bus.done, b);
        end
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic check_run(input int n, input int unsigned step, input string name);
        int unsigned e, expCyc, nu;
        logic        expTo;
        int          expDoneLat;
        nu = n;
        e  = (step == 0) ? 32'hFFFF_FFFF : (4 * nu + step - 1) / step;
        expTo  = (e > MC - 1);
        expCyc = expTo ? MC - 1 : e;

        checks++;
        if (wrAddr.size() != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wrAddr.size(), n);
        end
        for (int i = 0; i < n && i < wrAddr.size(); i++) begin
            checks++;
            if (wrAddr[i] !== 32'(4 * i) || wrData[i] !== prog[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         name, i, wrAddr[i], wrData[i], 32'(4 * i), prog[i]);
            end
        end
        checks++;
        if (badWr != 0) begin
            errors++;
            $display("FAIL %s write_without_valid: got %0d, required 0", name, badWr);
        end
        if (wrCyc.size() > 0) begin
            checks++;
            if (firstRun != wrCyc[wrCyc.size() - 1] + 1) begin
                errors++;
                $display("FAIL %s run_entry: first pcWrite cycle %0d, required %0d",
                         name, firstRun, wrCyc[wrCyc.size() - 1] + 1);
            end
        end
        checks++;
        if (runCnt != int'(expCyc) + 1) begin
            errors++;
            $display("FAIL %s run_cycles: got %0d, required %0d", name, runCnt, expCyc + 1);
        end
        checks++;
        if (bus.cycleNo !== 16'(expCyc)) begin
            errors++;
            $display("FAIL %s cycleNo: got %0d, required %0d", name, bus.cycleNo, expCyc);
        end
        checks++;
        if (bus.timeout !== expTo) begin
            errors++;
            $display("FAIL %s timeout: got %b, required %b", name, bus.timeout, expTo);
        end
        checks++;
        if (bus.progErr !== 1'b0) begin
            errors++;
            $display("FAIL %s progErr: got %b, required 0", name, bus.progErr);
        end
`ifdef BOOT_REGDUMP_EN
        expDoneLat = int'(NR) + 2;
        checks++;
        if (dIdx.size() != int'(NR)) begin
            errors++;
            $display("FAIL %s dump_count: got %0d, required %0d", name, dIdx.size(), NR);
        end
        for (int i = 0; i < int'(NR) && i < dIdx.size(); i++) begin
            checks++;
            if (dIdx[i] !== 5'(i) || dData[i] !== regs[i]) begin
                errors++;
                $display("FAIL %s dump[%0d]: got idx=%0d data=%h, required idx=%0d data=%h",
                         name, i, dIdx[i], dData[i], i, regs[i]);
            end
        end
`else
        expDoneLat = 1;
        checks++;
        if (dIdx.size() != 0 || dumpEnCnt != 0) begin
            errors++;
            $display("FAIL %s dump_absent: got valid=%0d regEn=%0d, required 0 0",
                     name, dIdx.size(), dumpEnCnt);
        end
`endif
        checks++;
        if (doneCyc != lastRun + expDoneLat) begin
            errors++;
            $display("FAIL %s done_latency: done at %0d, required %0d", name, doneCyc, lastRun + expDoneLat);
        end
    endtask

    task automatic run_prog(input int n, input int unsigned step, input string name);
        clear_mon();
        pcStep = step;
        start_prog(n);
        load_words(n);
        wait_done(400, name);
        check_run(n, step, name);
    endtask

    task automatic check_reset_vals(input string name);
        logic [10:0] obs;
        obs = {bus.pcReset, bus.initializing, bus.instrWrite, bus.instrRead, bus.pcWrite,
               bus.loadReady, bus.dumpRegEn, bus.dumpValid, bus.done, bus.timeout, bus.progErr};
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL %s outputs: got %b, required %b", name, obs, RESET_VEC);
        end
        checks++;
        if (bus.cycleNo !== 16'd0) begin
            errors++;
            $display("FAIL %s cycleNo: got %0d, required 0", name, bus.cycleNo);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.progLen = '0; bus.loadValid = 1'b0; bus.loadData = '0;
        resetN = 1'b0;
        #2;
        check_reset_vals("reset_asserted");
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("idle_after_reset");
    endtask

    task automatic test_load_basic();
        fill_random(2);
        prog[0] = 32'h2010_0002;
        prog[1] = 32'h2210_0003;
        run_prog(2, 4, "load_basic");
        checks++;
        if (wrCyc.size() != 2 || wrCyc[1] != wrCyc[0] + 1) begin
            errors++;
            $display("FAIL load_basic back_to_back: got %0d writes, required 2 in consecutive cycles", wrCyc.size());
        end
    endtask

    task automatic test_load_stall();
        fill_random(2);
        prog[0]  = 32'h2010_0002;
        prog[1]  = 32'h2210_0003;
        stall[1] = 3;
        run_prog(2, 4, "load_stall");
        checks++;
        if (wrCyc.size() != 2 || wrCyc[1] != wrCyc[0] + 4) begin
            errors++;
            $display("FAIL load_stall gap: got %0d writes, required 2 spaced 4 cycles apart", wrCyc.size());
        end
    endtask

    task automatic test_watchdog();
        fill_random(3);
        run_prog(3, 0, "watchdog_stuck_pc");
        fill_random(15);
        run_prog(15, 4, "watchdog_tie_pc_wins");
        fill_random(16);
        run_prog(16, 4, "watchdog_one_past");
    endtask

    task automatic test_progerr();
        int lens [3] = '{0, 257, 256};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            clear_mon();
            start_prog(lens[k]);
            checks++;
            if (k < 2) begin
                if (bus.done !== 1'b1 || bus.progErr !== 1'b1) begin
                    errors++;
                    $display("FAIL progerr_len%0d: got done=%b progErr=%b, required 1 1",
                             lens[k], bus.done, bus.progErr);
                end
                repeat (3) begin @(posedge clk); #1; end
                checks++;
                if (wrAddr.size() != 0 || runCnt != 0 || bus.done !== 1'b1) begin
                    errors++;
                    $display("FAIL progerr_len%0d quiet: got writes=%0d pcWrite=%0d done=%b, required 0 0 1",
                             lens[k], wrAddr.size(), runCnt, bus.done);
                end
            end else begin
                if (bus.progErr !== 1'b0 || bus.loadReady !== 1'b1) begin
                    errors++;
                    $display("FAIL progerr_len256 accept: got progErr=%b loadReady=%b, required 0 1",
                             bus.progErr, bus.loadReady);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_start_ignored();
        fill_random(4);
        clear_mon();
        pcStep = 4;
        start_prog(4);
        bus.start = 1'b1; bus.progLen = 16'd1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.progLen = 16'd77;
        load_words(4);
        bus.start = 1'b1; bus.progLen = 16'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(400, "start_ignored");
        check_run(4, 4, "start_ignored");
    endtask

    task automatic test_reset_mid();
        int b;
        fill_random(3);
        clear_mon();
        pcStep = 0;
        start_prog(3);
        load_words(3);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (bus.pcWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run in_run: pcWrite=%b, required 1", bus.pcWrite);
        end
        resetN = 1'b0;
        #1;
        check_reset_vals("reset_mid_run");
        @(posedge clk); #1 resetN = 1'b1;
        fill_random(2);
        run_prog(2, 4, "reload_after_run_reset");
`ifdef BOOT_REGDUMP_EN
        fill_random(1);
        clear_mon();
        pcStep = 4;
        start_prog(1);
        load_words(1);
        b = 0;
        while (!bus.dumpRegEn && b < 50) begin @(posedge clk); #1; b++; end
        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (bus.dumpRegEn !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_dump in_dump: dumpRegEn=%b, required 1", bus.dumpRegEn);
        end
        resetN = 1'b0;
        #1;
        check_reset_vals("reset_mid_dump");
        @(posedge clk); #1 resetN = 1'b1;
        fill_random(3);
        run_prog(3, 4, "reload_after_dump_reset");
`else
        b = 0;
`endif
    endtask

    task automatic test_random();
        int          n;
        int unsigned step;
        for (int it = 0; it < 8; it++) begin
            n    = $urandom_range(1, 8);
            step = 4 * $urandom_range(0, 3);
            fill_random(n);
            for (int i = 0; i < n; i++) stall[i] = $urandom_range(0, 2);
            run_prog(n, step, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_stall();
        test_watchdog();
        test_progerr();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
